// File: rtl/tx_frame_scheduler_if.sv
// Handshake between the TX frame scheduler and the XGMII frame generator,
// plus the ARP-reply strobe coming back from the RX parser.
interface tx_frame_scheduler_if;
   logic        gen_start;
   logic [1:0]  gen_kind;
   logic        gen_busy;
   logic        gen_done;
   logic        arp_reply_valid;
   logic [47:0] arp_reply_mac;

   modport master (
      output gen_start, gen_kind,
      input  gen_busy, gen_done, arp_reply_valid, arp_reply_mac
   );

   modport slave (
      input  gen_start, gen_kind,
      output gen_busy, gen_done, arp_reply_valid, arp_reply_mac
   );
endinterface

// File: rtl/tx_frame_scheduler.sv
// Port-0 TX sequencer: frame start/kind, inter-frame gap, gateway ARP with
// timeout/retry, per-frame field stepping and per-second pps/throughput.
//
// state       | meaning
// ------------+-----------------------------------------------------------
// S_IDLE      | no traffic, or ARP failed while ARP is required
// S_REQ_ARP   | one ARP request frame: start it, wait for gen_done
// S_WAIT_ARP  | down-count ARP_TIMEOUT waiting for the gateway reply
// S_V4_SEND   | one IPv4 data frame: start it, wait for gen_done
// S_V6_SEND   | one IPv6 data frame: start it, wait for gen_done
// S_GAP       | down-count tx_ifg idle cycles before the next decision
module tx_frame_scheduler #(
   parameter logic [31:0] ARP_TIMEOUT    = 32'd15625000,
   parameter int unsigned ARP_RETRY_MAX  = 3,
   parameter logic [23:0] FULL_IPV4_INIT = 24'h000000
) (
   input  logic        sys_clk,
   input  logic        sys_rst,
   input  logic        sec_oneshot,
   input  logic        tx_enable,
   input  logic        tx_ipv6,
   input  logic        tx_fullroute,
   input  logic        tx_req_arp,
   input  logic [15:0] tx_frame_len,
   input  logic [31:0] tx_ifg,
   tx_frame_scheduler_if.master gen_if,
   output logic [47:0] dst_mac,
   output logic        arp_resolved,
   output logic        arp_fail,
   output logic [15:0] ipv4_id,
   output logic [23:0] full_ipv4,
   output logic [31:0] tx_pps,
   output logic [31:0] tx_throughput
);

   typedef enum logic [2:0] {
      S_IDLE     = 3'd0,
      S_REQ_ARP  = 3'd1,
      S_WAIT_ARP = 3'd2,
      S_V4_SEND  = 3'd3,
      S_V6_SEND  = 3'd4,
      S_GAP      = 3'd5
   } state_t;

   localparam logic [1:0] KIND_ARP  = 2'd0;
   localparam logic [1:0] KIND_V4   = 2'd1;
   localparam logic [1:0] KIND_V6   = 2'd2;
   localparam logic [7:0] RETRY_MAX = 8'(ARP_RETRY_MAX);

   state_t      state_q, state_d;
   logic        started_q, started_d;
   logic [1:0]  kind_q, kind_d;
   logic        en_q, en_d;
   logic [31:0] timer_q, timer_d;
   logic [7:0]  retries_q, retries_d;
   logic [47:0] mac_q, mac_d;
   logic        resolved_q, resolved_d;
   logic        fail_q, fail_d;
   logic [15:0] id_q, id_d;
   logic [23:0] full_q, full_d;
   logic [31:0] frame_q, frame_d;
   logic [31:0] byte_q, byte_d;
   logic [31:0] pps_q, pps_d;
   logic [31:0] thr_q, thr_d;

   logic        en_rise;
   logic        in_frame;
   logic        data_state;
   logic        start_now;
   logic        done_ok;
   logic        data_done;
   logic [1:0]  kind_now;
   logic [7:0]  retries_inc;
   logic [31:0] frame_inc;
   logic [32:0] byte_sum;
   logic [31:0] byte_inc;
   state_t      dispatch;

   assign en_rise     = tx_enable & ~en_q;
   assign data_state  = (state_q == S_V4_SEND) || (state_q == S_V6_SEND);
   assign in_frame    = data_state || (state_q == S_REQ_ARP);
   assign start_now   = in_frame & ~started_q & ~gen_if.gen_busy;
   assign done_ok     = in_frame & started_q & gen_if.gen_done;
   assign data_done   = done_ok & data_state;
   assign retries_inc = retries_q + 8'd1;
   assign byte_sum    = {1'b0, byte_q} + {17'd0, tx_frame_len};

   always_comb begin
      kind_now = KIND_ARP;
      if (state_q == S_V4_SEND) kind_now = KIND_V4;
      if (state_q == S_V6_SEND) kind_now = KIND_V6;
   end

   // gen_kind shows the new kind in the start cycle itself, then holds it.
   assign gen_if.gen_start = start_now;
   assign gen_if.gen_kind  = start_now ? kind_now : kind_q;

   always_comb begin
      state_d    = state_q;
      started_d  = started_q;
      kind_d     = kind_q;
      en_d       = tx_enable;
      timer_d    = timer_q;
      retries_d  = retries_q;
      mac_d      = mac_q;
      resolved_d = resolved_q;
      fail_d     = fail_q;
      id_d       = id_q;
      full_d     = full_q;
      dispatch   = S_IDLE;

      if (en_rise) begin
         mac_d      = '1;
         resolved_d = 1'b0;
         fail_d     = 1'b0;
         retries_d  = '0;
      end

      if (start_now) begin
         started_d = 1'b1;
         kind_d    = kind_now;
      end

      // Next frame choice; uses the post-rise-edge ARP status.
      if (tx_req_arp && !resolved_d && !fail_d) begin
         dispatch = S_REQ_ARP;
      end else if (tx_req_arp && fail_d) begin
         dispatch = S_IDLE;
      end else if (tx_ipv6) begin
         dispatch = S_V6_SEND;
      end else begin
         dispatch = S_V4_SEND;
      end

      case (state_q)
         S_IDLE: begin
            if (tx_enable) state_d = dispatch;
         end
         S_REQ_ARP: begin
            if (done_ok) begin
               state_d = S_WAIT_ARP;
               timer_d = ARP_TIMEOUT;
            end
         end
         S_WAIT_ARP: begin
            if (!tx_enable) begin
               state_d = S_IDLE;
            end else if (gen_if.arp_reply_valid) begin
               mac_d      = gen_if.arp_reply_mac;
               resolved_d = 1'b1;
               retries_d  = '0;
               state_d    = S_GAP;
               timer_d    = tx_ifg;
            end else if (timer_q == '0) begin
               retries_d = retries_inc;
               if (retries_inc == RETRY_MAX) begin
                  fail_d  = 1'b1;
                  state_d = S_IDLE;
               end else begin
                  state_d = S_REQ_ARP;
               end
            end else begin
               timer_d = timer_q - 32'd1;
            end
         end
         S_V4_SEND, S_V6_SEND: begin
            if (done_ok) begin
               if (state_q == S_V4_SEND) id_d = id_q + 16'd1;
               if (tx_fullroute) full_d = full_q + 24'd1;
               state_d = S_GAP;
               timer_d = tx_ifg;
            end
         end
         S_GAP: begin
            if (timer_q == '0) begin
               state_d = tx_enable ? dispatch : S_IDLE;
            end else begin
               timer_d = timer_q - 32'd1;
            end
         end
         default: state_d = S_IDLE;
      endcase

      // Every state change is a new visit, so a new start may be issued.
      if (state_d != state_q) started_d = 1'b0;
   end

   always_comb begin
      frame_inc = frame_q;
      byte_inc  = byte_q;
      if (data_done) begin
         if (frame_q != '1) frame_inc = frame_q + 32'd1;
         byte_inc = byte_sum[32] ? '1 : byte_sum[31:0];
      end

      pps_d   = pps_q;
      thr_d   = thr_q;
      frame_d = frame_inc;
      byte_d  = byte_inc;
      if (sec_oneshot) begin
         pps_d   = frame_inc;
         thr_d   = byte_inc;
         frame_d = '0;
         byte_d  = '0;
      end
   end

   always_ff @(posedge sys_clk or negedge sys_rst) begin
      if (!sys_rst) begin
         state_q    <= S_IDLE;
         started_q  <= 1'b0;
         kind_q     <= KIND_ARP;
         en_q       <= 1'b0;
         timer_q    <= '0;
         retries_q  <= '0;
         mac_q      <= '1;
         resolved_q <= 1'b0;
         fail_q     <= 1'b0;
         id_q       <= '0;
         full_q     <= FULL_IPV4_INIT;
         frame_q    <= '0;
         byte_q     <= '0;
         pps_q      <= '0;
         thr_q      <= '0;
      end else begin
         state_q    <= state_d;
         started_q  <= started_d;
         kind_q     <= kind_d;
         en_q       <= en_d;
         timer_q    <= timer_d;
         retries_q  <= retries_d;
         mac_q      <= mac_d;
         resolved_q <= resolved_d;
         fail_q     <= fail_d;
         id_q       <= id_d;
         full_q     <= full_d;
         frame_q    <= frame_d;
         byte_q     <= byte_d;
         pps_q      <= pps_d;
         thr_q      <= thr_d;
      end
   end

   assign dst_mac       = mac_q;
   assign arp_resolved  = resolved_q;
   assign arp_fail      = fail_q;
   assign ipv4_id       = id_q;
   assign full_ipv4     = full_q;
   assign tx_pps        = pps_q;
   assign tx_throughput = thr_q;

endmodule

// File: tb/tb_tx_frame_scheduler.sv
// Directed bench for tx_frame_scheduler; a second instance with a preset
// full-route counter runs in lockstep to reach the 24-bit wrap quickly.
module tb_tx_frame_scheduler;
   logic        sys_clk = 1'b0;
   logic        sys_rst;
   logic        sec_oneshot, tx_enable, tx_ipv6, tx_fullroute, tx_req_arp;
   logic [15:0] tx_frame_len;
   logic [31:0] tx_ifg;

   logic [47:0] dst_mac, dst_mac_w;
   logic        arp_resolved, arp_resolved_w, arp_fail, arp_fail_w;
   logic [15:0] ipv4_id, ipv4_id_w;
   logic [23:0] full_ipv4, full_ipv4_w;
   logic [31:0] tx_pps, tx_pps_w, tx_throughput, tx_throughput_w;

   tx_frame_scheduler_if gif ();
   tx_frame_scheduler_if wif ();

   assign wif.gen_busy        = gif.gen_busy;
   assign wif.gen_done        = gif.gen_done;
   assign wif.arp_reply_valid = gif.arp_reply_valid;
   assign wif.arp_reply_mac   = gif.arp_reply_mac;

   tx_frame_scheduler #(.ARP_TIMEOUT(32'd100)) dut (
      .sys_clk(sys_clk), .sys_rst(sys_rst), .sec_oneshot(sec_oneshot),
      .tx_enable(tx_enable), .tx_ipv6(tx_ipv6), .tx_fullroute(tx_fullroute),
      .tx_req_arp(tx_req_arp), .tx_frame_len(tx_frame_len), .tx_ifg(tx_ifg),
      .gen_if(gif), .dst_mac(dst_mac), .arp_resolved(arp_resolved),
      .arp_fail(arp_fail), .ipv4_id(ipv4_id), .full_ipv4(full_ipv4),
      .tx_pps(tx_pps), .tx_throughput(tx_throughput)
   );

   tx_frame_scheduler #(.ARP_TIMEOUT(32'd100), .FULL_IPV4_INIT(24'hfffffe)) dut_w (
      .sys_clk(sys_clk), .sys_rst(sys_rst), .sec_oneshot(sec_oneshot),
      .tx_enable(tx_enable), .tx_ipv6(tx_ipv6), .tx_fullroute(tx_fullroute),
      .tx_req_arp(tx_req_arp), .tx_frame_len(tx_frame_len), .tx_ifg(tx_ifg),
      .gen_if(wif), .dst_mac(dst_mac_w), .arp_resolved(arp_resolved_w),
      .arp_fail(arp_fail_w), .ipv4_id(ipv4_id_w), .full_ipv4(full_ipv4_w),
      .tx_pps(tx_pps_w), .tx_throughput(tx_throughput_w)
   );

   always #5 sys_clk = ~sys_clk;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;
   int starts = 0;

   always @(posedge sys_clk) cyc <= cyc + 1;
   always @(negedge sys_clk) if (gif.gen_start === 1'b1) starts <= starts + 1;

   logic [1:0]  s_kind;
   logic [15:0] s_id;
   logic [23:0] s_full, s_full_w;
   int          s_cyc;
   bit          s_seen;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge sys_clk);
      #1;
   endtask

   task automatic wait_start();
      s_seen = 1'b0;
      for (int i = 0; i < 400 && !s_seen; i++) begin
         @(negedge sys_clk);
         if (gif.gen_start === 1'b1) s_seen = 1'b1;
      end
      check("start_seen", 64'(s_seen), 64'(1));
      s_cyc    = cyc;
      s_kind   = gif.gen_kind;
      s_id     = ipv4_id;
      s_full   = full_ipv4;
      s_full_w = full_ipv4_w;
   endtask

   // Generator model: busy from the cycle after start, gen_done d cycles after start.
   task automatic do_frame(input int d, input bit with_sec);
      wait_start();
      if (s_seen) begin
         step(1);
         gif.gen_busy = 1'b1;
         step(d - 1);
         gif.gen_done = 1'b1;
         sec_oneshot  = with_sec;
         step(1);
         gif.gen_done = 1'b0;
         gif.gen_busy = 1'b0;
         sec_oneshot  = 1'b0;
      end
   endtask

   task automatic pulse_sec();
      sec_oneshot = 1'b1;
      step(1);
      sec_oneshot = 1'b0;
   endtask

   initial begin
      int prev;
      int base;
      sys_rst             = 1'b0;
      sec_oneshot         = 1'b0;
      tx_enable           = 1'b0;
      tx_ipv6             = 1'b0;
      tx_fullroute        = 1'b0;
      tx_req_arp          = 1'b0;
      tx_frame_len        = 16'd64;
      tx_ifg              = 32'd5;
      gif.gen_busy        = 1'b0;
      gif.gen_done        = 1'b0;
      gif.arp_reply_valid = 1'b0;
      gif.arp_reply_mac   = 48'h0;
      step(3);
      sys_rst = 1'b1;

      // T1: idle after reset
      step(1000);
      check("t1_starts", 64'(starts), 64'(0));
      check("t1_kind", 64'(gif.gen_kind), 64'(0));
      check("t1_dst_mac", 64'(dst_mac), 64'(48'hffffffffffff));
      check("t1_resolved", 64'(arp_resolved), 64'(0));
      check("t1_fail", 64'(arp_fail), 64'(0));
      check("t1_ipv4_id", 64'(ipv4_id), 64'(0));
      check("t1_full", 64'(full_ipv4), 64'(0));
      check("t1_pps", 64'(tx_pps), 64'(0));
      check("t1_thr", 64'(tx_throughput), 64'(0));

      // T2: IPv4, len 64, ifg 5, done 8 cycles after start
      tx_enable = 1'b1;
      prev = 0;
      for (int f = 0; f < 4; f++) begin
         do_frame(8, 1'b0);
         check("t2_kind", 64'(s_kind), 64'(1));
         check("t2_id", 64'(s_id), 64'(f));
         check("t2_full", 64'(s_full), 64'(0));
         if (f > 0) check("t2_spacing", 64'(s_cyc - prev), 64'(15));
         prev = s_cyc;
      end
      tx_enable = 1'b0;
      step(20);
      check("t2_starts", 64'(starts), 64'(4));
      check("t2_ipv4_id", 64'(ipv4_id), 64'(4));
      check("t2_pps_pre", 64'(tx_pps), 64'(0));
      pulse_sec();
      check("t2_pps", 64'(tx_pps), 64'(4));
      check("t2_thr", 64'(tx_throughput), 64'(256));

      // T5: 10 frames of 100 B, sec_oneshot with the 11th gen_done
      tx_frame_len = 16'd100;
      tx_ifg       = 32'd2;
      tx_enable    = 1'b1;
      for (int f = 0; f < 10; f++) do_frame(4, 1'b0);
      do_frame(4, 1'b1);
      tx_enable = 1'b0;
      check("t5_pps", 64'(tx_pps), 64'(11));
      check("t5_thr", 64'(tx_throughput), 64'(1100));
      check("t5_ipv4_id", 64'(ipv4_id), 64'(15));
      step(10);
      pulse_sec();
      check("t5_pps_next", 64'(tx_pps), 64'(0));
      check("t5_thr_next", 64'(tx_throughput), 64'(0));

      // T3: ARP resolved by a reply
      tx_req_arp = 1'b1;
      tx_enable  = 1'b1;
      do_frame(4, 1'b0);
      check("t3_arp_kind", 64'(s_kind), 64'(0));
      step(10);
      check("t3_resolved_pre", 64'(arp_resolved), 64'(0));
      check("t3_mac_pre", 64'(dst_mac), 64'(48'hffffffffffff));
      gif.arp_reply_mac   = 48'h0037760001aa;
      gif.arp_reply_valid = 1'b1;
      step(1);
      gif.arp_reply_valid = 1'b0;
      check("t3_resolved", 64'(arp_resolved), 64'(1));
      check("t3_mac", 64'(dst_mac), 64'(48'h0037760001aa));
      do_frame(4, 1'b0);
      check("t3_data_kind", 64'(s_kind), 64'(1));
      check("t3_id", 64'(s_id), 64'(15));
      gif.arp_reply_mac   = 48'h112233445566;
      gif.arp_reply_valid = 1'b1;
      step(1);
      gif.arp_reply_valid = 1'b0;
      check("t3_stray_reply", 64'(dst_mac), 64'(48'h0037760001aa));
      do_frame(4, 1'b0);
      check("t3_data_kind2", 64'(s_kind), 64'(1));
      tx_enable = 1'b0;
      step(10);
      pulse_sec();
      check("t3_pps", 64'(tx_pps), 64'(2));
      check("t3_thr", 64'(tx_throughput), 64'(200));
      check("t3_ipv4_id", 64'(ipv4_id), 64'(17));

      // T4: no reply, three ARP attempts then failure
      base      = starts;
      tx_enable = 1'b1;
      do_frame(4, 1'b0);
      check("t4_kind0", 64'(s_kind), 64'(0));
      check("t4_mac_cleared", 64'(dst_mac), 64'(48'hffffffffffff));
      check("t4_resolved_cleared", 64'(arp_resolved), 64'(0));
      prev = s_cyc;
      do_frame(4, 1'b0);
      check("t4_kind1", 64'(s_kind), 64'(0));
      check("t4_spacing1", 64'(s_cyc - prev), 64'(106));
      check("t4_fail_early", 64'(arp_fail), 64'(0));
      prev = s_cyc;
      do_frame(4, 1'b0);
      check("t4_kind2", 64'(s_kind), 64'(0));
      check("t4_spacing2", 64'(s_cyc - prev), 64'(106));
      step(150);
      check("t4_fail", 64'(arp_fail), 64'(1));
      check("t4_arp_starts", 64'(starts - base), 64'(3));
      check("t4_resolved", 64'(arp_resolved), 64'(0));

      // ARP no longer required: data frames resume, IPv6 leaves ipv4_id alone
      tx_req_arp = 1'b0;
      do_frame(4, 1'b0);
      check("rec_v4_kind", 64'(s_kind), 64'(1));
      tx_ipv6 = 1'b1;
      do_frame(4, 1'b0);
      check("rec_v6_kind", 64'(s_kind), 64'(2));
      check("rec_v6_id", 64'(s_id), 64'(18));
      check("rec_id_hold", 64'(ipv4_id), 64'(18));

      // T6: full-route wrap, then async reset mid-frame
      tx_ipv6      = 1'b0;
      tx_fullroute = 1'b1;
      do_frame(4, 1'b0);
      check("t6_full_w0", 64'(s_full_w), 64'(24'hfffffe));
      check("t6_full0", 64'(s_full), 64'(0));
      do_frame(4, 1'b0);
      check("t6_full_w1", 64'(s_full_w), 64'(24'hffffff));
      check("t6_full1", 64'(s_full), 64'(1));
      wait_start();
      check("t6_full_wrap", 64'(s_full_w), 64'(24'h000000));
      check("t6_full2", 64'(s_full), 64'(2));
      step(1);
      gif.gen_busy = 1'b1;
      step(1);
      #2;
      sys_rst = 1'b0;
      #1;
      check("t6_rst_start", 64'(gif.gen_start), 64'(0));
      check("t6_rst_kind", 64'(gif.gen_kind), 64'(0));
      check("t6_rst_id", 64'(ipv4_id), 64'(0));
      check("t6_rst_full", 64'(full_ipv4), 64'(0));
      check("t6_rst_full_w", 64'(full_ipv4_w), 64'(24'hfffffe));
      check("t6_rst_mac", 64'(dst_mac), 64'(48'hffffffffffff));
      check("t6_rst_fail", 64'(arp_fail), 64'(0));
      check("t6_rst_pps", 64'(tx_pps), 64'(0));
      check("t6_rst_thr", 64'(tx_throughput), 64'(0));
      gif.gen_busy = 1'b0;
      tx_enable    = 1'b0;
      tx_fullroute = 1'b0;
      base         = starts;
      step(3);
      sys_rst = 1'b1;
      step(20);
      check("t6_post_rst_starts", 64'(starts - base), 64'(0));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
